// File: rtl/od_driver_bank_if.sv
// Signal bundle for od_driver_bank: logic inputs, global enable, fault clear
// and the per-channel pull/fault status returned by the bank.
interface od_driver_bank_if #(
  parameter int unsigned CHANNELS = 6
);
  logic [CHANNELS-1:0] a;
  logic                oe;
  logic                fault_clr;
  logic [CHANNELS-1:0] pull;
  logic [CHANNELS-1:0] fault;

  modport master (output a, oe, fault_clr, input pull, fault);
  modport slave  (input a, oe, fault_clr, output pull, fault);
endinterface

// File: rtl/od_driver_bank.sv
// Bank of open-drain drivers: per-channel glitch filter, clocked pipeline, oe/power gating.
// Define OD_READBACK_EN to add pin-readback contention detection (sticky fault flags).
module od_driver_bank #(
  parameter int unsigned CHANNELS  = 6,
  parameter int unsigned INVERT    = 1,
  parameter int unsigned FILTER    = 0,
  parameter int unsigned DELAY     = 2,
  parameter int unsigned FAULT_CYC = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vcc,
  input  logic                   gnd,
  od_driver_bank_if.slave        bus,
  inout  wire  [CHANNELS-1:0]    y
);

  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] known;
  logic [CHANNELS-1:0] filt;
  logic [CHANNELS-1:0] pull;
  logic [CHANNELS-1:0] drv;
  logic                pwr_ok;

  always_comb begin
    req   = '0;
    known = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      req[i]   = (INVERT != 0) ? bus.a[i] : ~bus.a[i];
      known[i] = (bus.a[i] === 1'b0) || (bus.a[i] === 1'b1);
    end
  end

  if (FILTER == 0) begin : g_nofilt
    assign filt = req;
  end else begin : g_filt
    localparam logic [7:0] FLT_LAST = 8'(FILTER - 1);
    logic [7:0]          cnt [CHANNELS];
    logic [CHANNELS-1:0] filt_q;

    // An unknown input counts as "no change": the pending count is dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        filt_q <= '0;
        for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (known[i] && (req[i] != filt_q[i])) begin
            if (cnt[i] == FLT_LAST) begin
              filt_q[i] <= req[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + 8'd1;
            end
          end else begin
            cnt[i] <= '0;
          end
        end
      end
    end

    assign filt = filt_q;
  end

  logic [CHANNELS-1:0] stage [DELAY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DELAY; k++) stage[k] <= '0;
    end else begin
      stage[0] <= filt;
      for (int unsigned k = 1; k < DELAY; k++) stage[k] <= stage[k-1];
    end
  end

  assign pull     = stage[DELAY-1];
  assign bus.pull = pull;

  // Gating is purely combinational so oe/power act without a clock edge
  // and never disturb the pipeline contents.
  assign pwr_ok = (vcc === 1'b1) && (gnd === 1'b0);
  assign drv    = pull & {CHANNELS{bus.oe & pwr_ok}};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_pin
    assign y[i] = drv[i] ? 1'b0 : 1'bz;
  end

`ifdef OD_READBACK_EN
  localparam logic [7:0] F_CAP  = 8'(FAULT_CYC);
  localparam logic [7:0] F_LAST = 8'(FAULT_CYC - 1);
  logic [7:0]          cnt_f [CHANNELS];
  logic [CHANNELS-1:0] bad;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] fault_q;

  always_comb begin
    bad = '0;
    hit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      bad[i] = drv[i] && (y[i] !== 1'b0);
      hit[i] = bad[i] && (cnt_f[i] >= F_LAST);
    end
  end

  // Counter saturates; hit stays asserted while the fight persists, so a
  // clear during ongoing contention re-latches on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt_f[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!bad[i])               cnt_f[i] <= '0;
        else if (cnt_f[i] != F_CAP) cnt_f[i] <= cnt_f[i] + 8'd1;
      end
      fault_q <= (fault_q & ~{CHANNELS{bus.fault_clr}}) | hit;
    end
  end

  assign bus.fault = fault_q;
`else
  logic unused_readback;
  assign unused_readback = bus.fault_clr;
  assign bus.fault       = '0;
`endif

endmodule
